usb_system_cpu_cpu_oci_dct_packer: RTL
======================================

# usb_system_cpu_cpu_oci_dct_packer

Producer side of the Nios II OCI direct-compressed-trace (DCT) path. It accepts 2-bit trace symbols from the CPU trace logic and packs up to 15 of them into a 30-bit `dct_buffer` with its symbol count `dct_count`. Completed packets go to the trace sink (trace FIFO or simulation trace test bench) over a valid/ready handshake. Output is double-buffered: one accumulator plus one output register, so packing continues while a packet waits.

## Interface
- `SYM_W`, 2: trace symbol width in bits. Fixed; not overridable.
- `MAX_SYMS`, 15: symbols per full packet. Fixed, so that `SYM_W*MAX_SYMS = 30`.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `trace_enable`  in  1  while low, `sym_valid` is ignored. A 1→0 transition acts as a flush.
- `sym_valid`  in  1  symbol present this cycle.
- `sym`  in  2  symbol code.
- `sym_ready`  out  1  accumulator can take a symbol this cycle.
- `flush`  in  1  close the current partial packet.
- `dct_buffer`  out  30  packed symbols. Symbol k is at bits [2k+1:2k], first-accepted at the LSB. Bits above `2*dct_count` are 0.
- `dct_count`  out  4  number of valid symbols, 1..15.
- `dct_valid`  out  1  output register holds a packet.
- `dct_ready`  in  1  sink consumes the packet when `dct_valid` is also high.
- `overflow`  out  1  sticky: a symbol was dropped. Cleared only by `reset`.

## Operation
- **State:** accumulator `acc[29:0]`, `cnt[3:0]`, `flush_pend`, `en_d` (registered `trace_enable`), output register, `dct_valid`, `overflow`.
- **Ready:** `sym_ready = (cnt != 15) && !flush_pend`. Combinational from registers only.
- **Accept:** `sym_valid && trace_enable && sym_ready`. `sym` is written at bits `[2*cnt+1:2*cnt]` and `cnt` increments.
- **Drop:** `sym_valid && trace_enable && !sym_ready`. The symbol is discarded and `overflow` is set. The CPU cannot stall, so dropping is the only option.
- **Next state:** `next_cnt` / `next_acc` are the values after any accept this cycle.
- **Close request:** asserted when `next_cnt == 15`, or when (`flush` || `flush_pend` || (`en_d && !trace_enable`)) && `next_cnt != 0`.
- **Slot free:** `!dct_valid || dct_ready`.
- **Transfer:** close request && slot free. The output register loads `next_acc` / `next_cnt`; `dct_valid` is set; `acc`, `cnt` and `flush_pend` clear.
- **Deferred flush:** close request from a flush source, slot not free, `next_cnt > 0` → set `flush_pend`. Further symbols are refused until the transfer, so the packet boundary stays exact.
- **Empty flush:** a flush with `next_cnt == 0` is a no-op. No empty packet is ever emitted.
- **Handshake completion:** `dct_valid && dct_ready` with no transfer that cycle → `dct_valid` clears. With a transfer the same cycle, the register reloads and `dct_valid` stays 1, giving back-to-back packets.
- **Output hold:** `dct_buffer` / `dct_count` stay stable while `dct_valid && !dct_ready`.

## Timing
- **Reset:** one cycle of `reset` clears everything, taking effect at the next edge.
  - `dct_valid = 0`, `dct_buffer = 0`, `dct_count = 0`, `overflow = 0`, `sym_ready = 1`.
  - Internal `cnt = 0`, `flush_pend = 0`, `en_d = 0`.
  - Reset mid-packet discards both the accumulator and the pending output.
- **Latency:** symbol accepted at edge N that closes a packet → `dct_valid = 1` after edge N, visible in cycle N+1. Flush sampled at N → packet visible in cycle N+1 if the slot is free.
- **Simultaneous symbol and flush:** the symbol is included in the flushed packet.
- **Simultaneous flush and 15th symbol:** exactly one packet with count 15.
- **Accumulator full, output busy:** `cnt` stays at 15 and `sym_ready = 0` until `dct_ready`. Transfer occurs on the `dct_ready` cycle.
- **Throughput:** one symbol per cycle sustained while the sink holds `dct_ready = 1`.

## Test plan
- **Full packet:** `dct_ready = 1`, `trace_enable = 1`, 15 consecutive `sym = 01` → `dct_valid` one cycle after the 15th, `dct_buffer = 30'h15555555`, `dct_count = 15`, high for exactly one cycle.
- **Partial flush:** symbols `11`, `10`, `01`, then `flush` with no symbol → `dct_buffer = 30'h0000001B`, `dct_count = 3`. A flush with count 0 produces no `dct_valid`.
- **Backpressure and overflow:** `dct_ready = 0`, 31 symbols of `10`.
  - After the 30th, `sym_ready = 0`; the 31st is dropped and `overflow = 1`.
  - Then `dct_ready = 1` → two consecutive valid cycles, each `dct_buffer = 30'h2AAAAAAA`, `dct_count = 15`.
  - `overflow` remains 1 afterwards.
- **Deferred flush:** output busy, 4 symbols, `flush` → `sym_ready = 0` and the next symbol is dropped. On `dct_ready`, the second packet has `dct_count = 4`.
- **Trace disable:** 5 symbols of `11`, then `trace_enable` 1→0 → packet `dct_count = 5`, `dct_buffer = 30'h000003FF`. `sym_valid` while disabled → no accept, no overflow.
- **Reset mid-operation:** 7 symbols accepted plus one packet pending, then `reset` for one cycle.
  - All outputs at reset values.
  - The next symbol `01` followed by `flush` yields `dct_buffer = 30'h1`, `dct_count = 1`.

Source files
------------

// File: rtl/usb_system_cpu_cpu_oci_dct_packer.sv
// Direct-compressed-trace packer: gathers 2-bit trace symbols into 30-bit
// packets and hands them to the trace sink over a valid/ready handshake.
// There is one accumulator and one output register, so packing can go on
// while a finished packet waits for the sink.
module usb_system_cpu_cpu_oci_dct_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_enable,
    input  logic        sym_valid,
    input  logic [1:0]  sym,
    output logic        sym_ready,
    input  logic        flush,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        dct_valid,
    input  logic        dct_ready,
    output logic        overflow
);

    localparam int unsigned SYM_W    = 2;
    localparam int unsigned MAX_SYMS = 15;
    localparam int unsigned BUF_W    = SYM_W * MAX_SYMS;

    logic [BUF_W-1:0] acc_q, acc_d, next_acc;
    logic [3:0]       cnt_q, cnt_d, next_cnt;
    logic             flush_pend_q, flush_pend_d;
    logic             en_d_q;
    logic [BUF_W-1:0] out_buf_q, out_buf_d;
    logic [3:0]       out_cnt_q, out_cnt_d;
    logic             dct_valid_q, dct_valid_d;
    logic             overflow_q, overflow_d;

    logic       accept, drop, flush_src, close_req, slot_free, transfer;
    logic [4:0] shamt;

    // Symbol acceptance and the decision to close the current packet.
    always_comb begin
        sym_ready = (cnt_q != 4'(MAX_SYMS)) && !flush_pend_q;
        accept    = sym_valid && trace_enable && sym_ready;
        drop      = sym_valid && trace_enable && !sym_ready;
        shamt     = {cnt_q, 1'b0};
        next_acc  = acc_q;
        next_cnt  = cnt_q;
        if (accept) begin
            // Bits above the fill point are always zero, so OR-ing is enough.
            next_acc = acc_q | (BUF_W'(sym) << shamt);
            next_cnt = cnt_q + 4'd1;
        end
        // A falling trace_enable closes the packet just like an explicit flush.
        flush_src = flush || flush_pend_q || (en_d_q && !trace_enable);
        close_req = (next_cnt == 4'(MAX_SYMS)) || (flush_src && (next_cnt != 4'd0));
        slot_free = !dct_valid_q || dct_ready;
        transfer  = close_req && slot_free;
    end

    // Next-state for accumulator, output register and sticky overflow.
    always_comb begin
        acc_d        = next_acc;
        cnt_d        = next_cnt;
        flush_pend_d = flush_pend_q;
        out_buf_d    = out_buf_q;
        out_cnt_d    = out_cnt_q;
        dct_valid_d  = dct_valid_q;
        overflow_d   = overflow_q || drop;
        if (transfer) begin
            out_buf_d    = next_acc;
            out_cnt_d    = next_cnt;
            dct_valid_d  = 1'b1;
            acc_d        = '0;
            cnt_d        = 4'd0;
            flush_pend_d = 1'b0;
        end else begin
            if (dct_valid_q && dct_ready) begin
                dct_valid_d = 1'b0;
            end
            // Output busy: hold the boundary and refuse symbols until it drains.
            if (flush_src && (next_cnt != 4'd0)) begin
                flush_pend_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            cnt_q        <= 4'd0;
            flush_pend_q <= 1'b0;
            en_d_q       <= 1'b0;
            out_buf_q    <= '0;
            out_cnt_q    <= 4'd0;
            dct_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            en_d_q       <= trace_enable;
            out_buf_q    <= out_buf_d;
            out_cnt_q    <= out_cnt_d;
            dct_valid_q  <= dct_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dct_buffer = out_buf_q;
    assign dct_count  = out_cnt_q;
    assign dct_valid  = dct_valid_q;
    assign overflow   = overflow_q;

endmodule
